// File: rtl/run_ctrl.sv
// Debug run controller: gates the CPU clock enable for run/halt/step,
// breakpoint and EBREAK stops, and drives a timed CPU reset.
module run_ctrl #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter bit          EBREAK_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] step_num,
  input  logic        bkpt_en,
  input  logic [31:0] bkpt_addr,
  input  logic [31:0] pc_pc,
  input  logic [31:0] irom_inst,
  output logic        cpu_ce,
  output logic        cpu_rst_n,
  output logic [1:0]  state,
  output logic [1:0]  halt_cause,
  output logic [31:0] inst_cnt
);

  typedef enum logic [1:0] {
    S_HALT   = 2'b00,
    S_RUN    = 2'b01,
    S_STEP   = 2'b10,
    S_CPURST = 2'b11
  } st_t;

  localparam logic [1:0]  OP_RUN   = 2'b00;
  localparam logic [1:0]  OP_HALT  = 2'b01;
  localparam logic [1:0]  OP_STEP  = 2'b10;
  localparam logic [1:0]  OP_RESET = 2'b11;

  localparam logic [1:0]  C_CMD  = 2'b00;
  localparam logic [1:0]  C_BKPT = 2'b01;
  localparam logic [1:0]  C_STEP = 2'b10;
  localparam logic [1:0]  C_EBRK = 2'b11;

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);

  st_t         cs, cs_nxt;
  logic [7:0]  rc, rc_nxt;
  logic [15:0] sc, sc_nxt;
  logic        skip, skip_nxt;
  logic [1:0]  cause, cause_nxt;
  logic [31:0] ic, ic_nxt;
  logic        ce;

  logic        accept;
  logic        is_run, is_halt, is_step, is_reset;
  logic        hit_bk, hit_eb, stop;
  logic [1:0]  stop_cause;

  assign cmd_ready  = (cs != S_CPURST);
  assign cpu_rst_n  = (cs != S_CPURST);
  assign accept     = cmd_valid && cmd_ready;
  assign is_run     = accept && (cmd_op == OP_RUN);
  assign is_halt    = accept && (cmd_op == OP_HALT);
  assign is_step    = accept && (cmd_op == OP_STEP);
  assign is_reset   = accept && (cmd_op == OP_RESET);

  // EBREAK ignores the skip flag so it can never retire
  assign hit_bk     = bkpt_en && (pc_pc == bkpt_addr) && !skip;
  assign hit_eb     = EBREAK_HALT && (irom_inst == EBREAK);
  assign stop       = hit_bk || hit_eb;
  assign stop_cause = hit_bk ? C_BKPT : C_EBRK;

  always_comb begin
    cs_nxt    = cs;
    rc_nxt    = rc;
    sc_nxt    = sc;
    skip_nxt  = skip;
    cause_nxt = cause;
    ic_nxt    = ic;
    ce        = 1'b0;
    unique case (cs)
      S_HALT: begin
        unique case (1'b1)
          is_run:  cs_nxt = S_RUN;
          is_step: begin
            cs_nxt = S_STEP;
            sc_nxt = (step_num == 16'd0) ? 16'd1 : step_num;
          end
          is_halt: cause_nxt = C_CMD;
          default: ;
        endcase
      end
      S_RUN, S_STEP: begin
        if (is_reset) begin
          cs_nxt = cs;
        end else if (is_halt) begin
          cs_nxt    = S_HALT;
          cause_nxt = stop ? stop_cause : C_CMD;
        end else if (stop) begin
          // an accepted RUN/STEP keeps the state
          if (!accept) begin
            cs_nxt    = S_HALT;
            cause_nxt = stop_cause;
          end
        end else begin
          ce = 1'b1;
          if (cs == S_STEP) begin
            sc_nxt = sc - 16'd1;
            if (sc == 16'd1) begin
              cs_nxt    = S_HALT;
              cause_nxt = C_STEP;
            end
          end
        end
      end
      S_CPURST: begin
        if (rc == 8'd0) begin
          cs_nxt    = S_HALT;
          cause_nxt = C_CMD;
        end else begin
          rc_nxt = rc - 8'd1;
        end
      end
      default: cs_nxt = S_CPURST;
    endcase

    if (is_run || is_step) skip_nxt = 1'b1;
    else if (ce) skip_nxt = 1'b0;

    if (ce && (ic != 32'hFFFF_FFFF)) ic_nxt = ic + 32'd1;

    if (is_reset) begin
      cs_nxt    = S_CPURST;
      rc_nxt    = RST_LAST;
      sc_nxt    = 16'd0;
      skip_nxt  = 1'b0;
      cause_nxt = C_CMD;
      ic_nxt    = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs    <= S_CPURST;
      rc    <= RST_LAST;
      sc    <= 16'd0;
      skip  <= 1'b0;
      cause <= C_CMD;
      ic    <= 32'd0;
    end else begin
      cs    <= cs_nxt;
      rc    <= rc_nxt;
      sc    <= sc_nxt;
      skip  <= skip_nxt;
      cause <= cause_nxt;
      ic    <= ic_nxt;
    end
  end

  assign cpu_ce     = ce;
  assign state      = cs;
  assign halt_cause = cause;
  assign inst_cnt   = ic;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed sequences, a vector table, and random
// stimulus against a behavioural model with a tiny fetch-only CPU.
module tb_run_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] EBRK = 32'h0010_0073;
  localparam int RSTC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] step_num;
  logic        bkpt_en;
  logic [31:0] bkpt_addr;
  logic [31:0] pc_pc;
  logic [31:0] irom_inst;
  logic        cpu_ce;
  logic        cpu_rst_n;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic [31:0] inst_cnt;

  run_ctrl #(.RST_CYCLES(RSTC), .EBREAK_HALT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .step_num(step_num),
    .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr),
    .pc_pc(pc_pc), .irom_inst(irom_inst),
    .cpu_ce(cpu_ce), .cpu_rst_n(cpu_rst_n),
    .state(state), .halt_cause(halt_cause),
    .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mem [16];
  bit auto_pc;
  bit use_model;
  logic s_ce, s_ready, s_rstn;

  // behavioural model: mode 0 halt, 1 run, 2 step, 3 cpu reset
  int          m_mode, m_left, m_rstleft;
  logic [1:0]  m_cause, m_scause;
  logic [31:0] m_cnt;
  bit          m_skip, m_acc, m_stop, m_ce;

  typedef struct {
    logic        v;
    logic [1:0]  op;
    logic [15:0] num;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        e_ready;
    logic        e_ce;
    logic        e_rstn;
    logic [1:0]  e_state;
    logic [1:0]  e_cause;
  } vec_t;
  vec_t tbl [21];

  function automatic vec_t mk(logic v, logic [1:0] op, logic [15:0] num,
                              logic [31:0] pc, logic [31:0] inst,
                              logic rdy, logic ce, logic rn,
                              logic [1:0] st, logic [1:0] ca);
    vec_t r;
    r.v = v; r.op = op; r.num = num; r.pc = pc; r.inst = inst;
    r.e_ready = rdy; r.e_ce = ce; r.e_rstn = rn;
    r.e_state = st; r.e_cause = ca;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_pre();
    bit bk, eb, act;
    m_acc = cmd_valid && (m_mode != 3);
    bk = bkpt_en && (pc_pc == bkpt_addr) && !m_skip;
    eb = (irom_inst == EBRK);
    act = (m_mode == 1) || (m_mode == 2);
    m_stop = act && (bk || eb);
    m_scause = bk ? 2'd1 : 2'd3;
    m_ce = act && !m_stop && !(m_acc && (cmd_op == 2'd1 || cmd_op == 2'd3));
    chk("rnd_ready", {31'd0, s_ready}, {31'd0, m_mode != 3});
    chk("rnd_ce", {31'd0, s_ce}, {31'd0, m_ce});
    chk("rnd_rstn", {31'd0, s_rstn}, {31'd0, m_mode != 3});
  endtask

  task automatic model_reset(input int mode);
    m_mode = mode; m_rstleft = RSTC; m_cnt = 0;
    m_cause = 0; m_left = 0; m_skip = 0;
  endtask

  task automatic model_post();
    if (rst) begin
      model_reset(3);
    end else if (m_mode == 3) begin
      m_rstleft--;
      if (m_rstleft == 0) m_mode = 0;
    end else begin
      if (m_ce && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (m_acc && cmd_op == 2'd3) model_reset(3);
      else if (m_acc && cmd_op == 2'd1) begin
        m_mode = 0;
        m_cause = m_stop ? m_scause : 2'd0;
      end else if (m_mode == 0) begin
        if (m_acc && cmd_op == 2'd0) m_mode = 1;
        else if (m_acc && cmd_op == 2'd2) begin
          m_mode = 2;
          m_left = (step_num == 0) ? 1 : int'(step_num);
        end
      end else if (m_stop) begin
        if (!m_acc) begin m_mode = 0; m_cause = m_scause; end
      end else if (m_mode == 2) begin
        m_left--;
        if (m_left == 0) begin m_mode = 0; m_cause = 2'd2; end
      end
      if (m_acc && (cmd_op == 2'd0 || cmd_op == 2'd2)) m_skip = 1;
      else if (m_ce) m_skip = 0;
    end
    chk("rnd_state", {30'd0, state}, m_mode);
    chk("rnd_cause", {30'd0, halt_cause}, {30'd0, m_cause});
    chk("rnd_icnt", inst_cnt, m_cnt);
  endtask

  // entered just after a negedge with inputs applied
  task automatic cycle();
    #3;
    s_ce = cpu_ce; s_ready = cmd_ready; s_rstn = cpu_rst_n;
    if (use_model) model_pre();
    @(posedge clk);
    @(negedge clk);
    if (use_model) model_post();
    if (auto_pc) begin
      if (!s_rstn) pc_pc = 0;
      else if (s_ce) pc_pc = (pc_pc + 32'd4) & 32'h3c;
      irom_inst = mem[pc_pc[5:2]];
    end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [15:0] num);
    cmd_valid = 1'b1; cmd_op = op; step_num = num;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic run_to_halt(input string nm, output int nce,
                             output bit last_ce);
    nce = 0; last_ce = 0;
    for (int i = 0; i < 200; i++) begin
      if (state == 2'd0) break;
      cycle();
      last_ce = s_ce;
      if (s_ce) nce++;
    end
    chk({nm, "_halted"}, {30'd0, state}, 32'd0);
  endtask

  task automatic wait_cpurst(input string nm);
    int lo_rdy, lo_rn;
    lo_rdy = 0; lo_rn = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!s_ready) lo_rdy++;
      if (!s_rstn) lo_rn++;
      if (state == 2'd0) break;
    end
    chk({nm, "_rdy_low"}, lo_rdy, RSTC);
    chk({nm, "_rstn_low"}, lo_rn, RSTC);
    chk({nm, "_state"}, {30'd0, state}, 32'd0);
    chk({nm, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    chk({nm, "_icnt"}, inst_cnt, 32'd0);
    chk({nm, "_cause"}, {30'd0, halt_cause}, 32'd0);
  endtask

  initial begin
    int nce;
    bit lce;
    int r;
    for (int i = 0; i < 16; i++) mem[i] = NOP;
    auto_pc = 1; use_model = 0;
    cmd_valid = 0; cmd_op = 0; step_num = 0;
    bkpt_en = 0; bkpt_addr = 0; pc_pc = 0; irom_inst = NOP;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    wait_cpurst("por");
    chk("por_ce", {31'd0, cpu_ce}, 32'd0);

    cmd(2'd2, 16'd3);
    run_to_halt("step3", nce, lce);
    chk("step3_ce", nce, 3);
    chk("step3_icnt", inst_cnt, 32'd3);
    chk("step3_cause", {30'd0, halt_cause}, 32'd2);
    cmd(2'd2, 16'd0);
    run_to_halt("step0", nce, lce);
    chk("step0_ce", nce, 1);
    chk("step0_icnt", inst_cnt, 32'd4);
    chk("step0_cause", {30'd0, halt_cause}, 32'd2);

    cmd(2'd3, 16'd0);
    wait_cpurst("rcmd1");

    bkpt_en = 1; bkpt_addr = 32'h10;
    cmd(2'd0, 16'd0);
    run_to_halt("bkpt", nce, lce);
    chk("bkpt_ce", nce, 4);
    chk("bkpt_last_ce", {31'd0, lce}, 32'd0);
    chk("bkpt_icnt", inst_cnt, 32'd4);
    chk("bkpt_cause", {30'd0, halt_cause}, 32'd1);
    chk("bkpt_pc", pc_pc, 32'h10);
    cmd(2'd0, 16'd0);
    for (int i = 0; i < 10 && pc_pc != 32'h18; i++) cycle();
    chk("bkpt2_icnt", inst_cnt, 32'd6);
    chk("bkpt2_state", {30'd0, state}, 32'd1);
    bkpt_en = 0;
    for (int i = 0; i < 300 && inst_cnt != 32'd100; i++) cycle();
    chk("run100_icnt", inst_cnt, 32'd100);
    cmd_valid = 1; cmd_op = 2'd3;
    cycle();
    cmd_valid = 0;
    chk("rcmd2_ce", {31'd0, s_ce}, 32'd0);
    wait_cpurst("rcmd2");

    mem[2] = EBRK;
    irom_inst = mem[pc_pc[5:2]];
    cmd(2'd0, 16'd0);
    run_to_halt("ebrk", nce, lce);
    chk("ebrk_icnt", inst_cnt, 32'd2);
    chk("ebrk_cause", {30'd0, halt_cause}, 32'd3);
    chk("ebrk_pc", pc_pc, 32'h8);
    cmd(2'd0, 16'd0);
    run_to_halt("ebrk2", nce, lce);
    chk("ebrk2_ce", nce, 0);
    chk("ebrk2_icnt", inst_cnt, 32'd2);
    chk("ebrk2_cause", {30'd0, halt_cause}, 32'd3);
    mem[2] = NOP;

    tbl[0]  = mk(1, 2'd0, 0, 32'h40, NOP,  1, 0, 1, 2'd1, 2'd3);
    tbl[1]  = mk(0, 2'd0, 0, 32'h40, NOP,  1, 1, 1, 2'd1, 2'd3);
    tbl[2]  = mk(0, 2'd0, 0, 32'h44, NOP,  1, 1, 1, 2'd1, 2'd3);
    tbl[3]  = mk(1, 2'd1, 0, 32'h40, NOP,  1, 0, 1, 2'd0, 2'd1);
    tbl[4]  = mk(1, 2'd1, 0, 32'h00, NOP,  1, 0, 1, 2'd0, 2'd0);
    tbl[5]  = mk(1, 2'd2, 2, 32'h00, NOP,  1, 0, 1, 2'd2, 2'd0);
    tbl[6]  = mk(1, 2'd0, 0, 32'h40, NOP,  1, 1, 1, 2'd2, 2'd0);
    tbl[7]  = mk(0, 2'd0, 0, 32'h40, NOP,  1, 1, 1, 2'd0, 2'd2);
    tbl[8]  = mk(1, 2'd2, 0, 32'h00, NOP,  1, 0, 1, 2'd2, 2'd2);
    tbl[9]  = mk(0, 2'd0, 0, 32'h00, EBRK, 1, 0, 1, 2'd0, 2'd3);
    tbl[10] = mk(1, 2'd0, 0, 32'h40, EBRK, 1, 0, 1, 2'd1, 2'd3);
    tbl[11] = mk(0, 2'd0, 0, 32'h40, EBRK, 1, 0, 1, 2'd0, 2'd3);
    tbl[12] = mk(1, 2'd0, 0, 32'h00, NOP,  1, 0, 1, 2'd1, 2'd3);
    tbl[13] = mk(0, 2'd0, 0, 32'h00, NOP,  1, 1, 1, 2'd1, 2'd3);
    tbl[14] = mk(0, 2'd0, 0, 32'h40, EBRK, 1, 0, 1, 2'd0, 2'd1);
    tbl[15] = mk(1, 2'd0, 0, 32'h00, NOP,  1, 0, 1, 2'd1, 2'd1);
    tbl[16] = mk(1, 2'd2, 5, 32'h44, NOP,  1, 1, 1, 2'd1, 2'd1);
    tbl[17] = mk(1, 2'd0, 0, 32'h48, EBRK, 1, 0, 1, 2'd1, 2'd1);
    tbl[18] = mk(0, 2'd0, 0, 32'h48, NOP,  1, 1, 1, 2'd1, 2'd1);
    tbl[19] = mk(1, 2'd3, 0, 32'h00, NOP,  1, 0, 1, 2'd3, 2'd0);
    tbl[20] = mk(0, 2'd0, 0, 32'h00, NOP,  0, 0, 0, 2'd3, 2'd0);
    auto_pc = 0; bkpt_en = 1; bkpt_addr = 32'h40;
    foreach (tbl[i]) begin
      cmd_valid = tbl[i].v; cmd_op = tbl[i].op; step_num = tbl[i].num;
      pc_pc = tbl[i].pc; irom_inst = tbl[i].inst;
      cycle();
      chk($sformatf("tbl%0d_ready", i), {31'd0, s_ready}, {31'd0, tbl[i].e_ready});
      chk($sformatf("tbl%0d_ce", i), {31'd0, s_ce}, {31'd0, tbl[i].e_ce});
      chk($sformatf("tbl%0d_rstn", i), {31'd0, s_rstn}, {31'd0, tbl[i].e_rstn});
      chk($sformatf("tbl%0d_state", i), {30'd0, state}, {30'd0, tbl[i].e_state});
      chk($sformatf("tbl%0d_cause", i), {30'd0, halt_cause}, {30'd0, tbl[i].e_cause});
    end
    cmd_valid = 0; bkpt_en = 0; auto_pc = 1;
    pc_pc = 0; irom_inst = mem[0];
    for (int i = 0; i < 10 && state != 2'd0; i++) cycle();
    chk("tbl_end_state", {30'd0, state}, 32'd0);

    for (int i = 0; i < 16; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? EBRK : NOP;
    irom_inst = mem[pc_pc[5:2]];
    model_reset(0);
    use_model = 1;
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 19);
      cmd_op = (r < 8) ? 2'd0 : (r < 14) ? 2'd2 : (r < 18) ? 2'd1 : 2'd3;
      step_num = 16'($urandom_range(0, 4));
      bkpt_en = ($urandom_range(0, 3) != 0);
      bkpt_addr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 15) == 0) begin
        pc_pc = 32'($urandom_range(0, 15)) << 2;
        irom_inst = mem[pc_pc[5:2]];
      end
      cycle();
    end
    use_model = 0;
    rst = 0; cmd_valid = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, default 4: number of cycles cpu_rst_n is held low on a RESET command (legal range 1..255).
REQ-002 SHALL have parameter EBREAK_HALT, default 1: when 1, fetching EBREAK (32'h00100073) halts the CPU.
REQ-003 SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset of this block.
REQ-005 SHALL have port cmd_valid, input, 1: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1: a command is accepted in any cycle where cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_op, input, 2: 00 RUN, 01 HALT, 10 STEP, 11 RESET.
REQ-008 SHALL have port step_num, input, 16: instruction count for STEP, sampled on acceptance; 0 is treated as 1.
REQ-009 SHALL have port bkpt_en, input, 1: breakpoint enable.
REQ-010 SHALL have port bkpt_addr, input, 32: breakpoint PC.
REQ-011 SHALL have port pc_pc, input, 32: current CPU PC.
REQ-012 SHALL have port irom_inst, input, 32: instruction at pc_pc.
REQ-013 SHALL have port cpu_ce, output, 1: CPU clock enable; PC/RF/DRAM write commit only when 1.
REQ-014 SHALL have port cpu_rst_n, output, 1: active-low CPU reset.
REQ-015 SHALL have port state, output, 2: 00 HALT, 01 RUN, 10 STEP, 11 CPURST.
REQ-016 SHALL have port halt_cause, output, 2: 00 command/reset, 01 breakpoint, 10 step done, 11 EBREAK.
REQ-017 SHALL have port inst_cnt, output, 32: retired-instruction counter.

Function
REQ-018 cmd_ready SHALL be 1 in every state except CPURST.
REQ-019 cpu_ce SHALL be combinational: 1 only in RUN or STEP when no stop condition (REQ-021/REQ-022) holds this cycle; 0 in HALT and CPURST.
REQ-020 A one-cycle skip flag SHALL be set on acceptance of RUN or STEP; while set, breakpoint match is ignored; it clears after the first cpu_ce=1 cycle.
REQ-021 Breakpoint stop: in RUN or STEP, bkpt_en && pc_pc==bkpt_addr && !skip SHALL force cpu_ce=0 that cycle, next state HALT, halt_cause=01; the instruction at bkpt_addr is not executed.
REQ-022 EBREAK stop: with EBREAK_HALT=1, irom_inst==32'h00100073 in RUN or STEP SHALL force cpu_ce=0, next state HALT, halt_cause=11; this takes precedence over the skip flag (EBREAK never retires).
REQ-023 Same-cycle breakpoint and EBREAK SHALL report halt_cause=01.
REQ-024 HALT: RUN -> RUN; STEP -> STEP with step counter loaded with max(step_num,1); HALT -> stay, halt_cause=00; RESET -> CPURST.
REQ-025 RUN: HALT -> HALT, cause 00, cpu_ce=0 in the acceptance cycle; RUN/STEP accepted and ignored; RESET -> CPURST.
REQ-026 STEP: step counter SHALL decrement on each cpu_ce=1 cycle; the cycle it is 1 with cpu_ce=1 is the last enabled cycle, next state HALT, cause 10; HALT command aborts (cause 00, cpu_ce=0 that cycle); RUN/STEP ignored; RESET -> CPURST.
REQ-027 A command accepted in the same cycle as a stop condition SHALL win for next-state, except HALT/stop conflicts resolve to HALT with the stop condition's cause; cpu_ce stays 0 that cycle.
REQ-028 CPURST: cpu_rst_n=0 for exactly RST_CYCLES cycles, inst_cnt cleared, then HALT with cause 00.
REQ-029 inst_cnt SHALL increment by 1 on each cycle with cpu_ce=1 && cpu_rst_n=1, saturating at 32'hFFFFFFFF.

Reset
REQ-030 On rst=1 at a clock edge: state=CPURST with full RST_CYCLES count restarted, cpu_rst_n=0, cpu_ce=0, halt_cause=00, inst_cnt=0, step counter=0, skip=0; rst mid-STEP or mid-CPURST SHALL discard all progress.
REQ-031 After rst deasserts, the block SHALL reach HALT exactly RST_CYCLES cycles later with cmd_ready=1.

Verification
REQ-032 rst 1 cycle, then idle -> cpu_rst_n low 4 cycles, state=00, cpu_ce=0, inst_cnt=0.
REQ-033 STEP with step_num=3 from HALT -> cpu_ce high exactly 3 cycles, inst_cnt=3, halt_cause=10; step_num=0 -> 1 cycle.
REQ-034 bkpt_en=1, bkpt_addr=0x10, RUN from pc 0 advancing by 4 -> cpu_ce=0 when pc_pc=0x10, inst_cnt=4, cause 01; second RUN -> executes 0x10, continues.
REQ-035 RUN with irom_inst=0x00100073 at pc 0x8 -> halt at 0x8, cause 11, inst_cnt=2; RUN again -> halts immediately, inst_cnt unchanged.
REQ-036 RESET issued mid-RUN with inst_cnt=100 -> cmd_ready=0 for 4 cycles, inst_cnt=0, state HALT afterwards.
REQ-037 HALT command in the same cycle as a breakpoint match -> state HALT, cause 01, cpu_ce=0.
